// File: rtl/wshb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : wshb_ram_slave
// Description : Wishbone B4 slave on single-port RAM, classic and linear
//               incrementing bursts (zero wait states on continuation beats).
// Revision    : 1.0 - initial release
// ============================================================================
module wshb_ram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cyc,
    input  logic                    stb,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   adr,
    input  logic [DATA_WIDTH-1:0]   dat_ms,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic [2:0]              cti,
    input  logic [1:0]              bte,
    output logic                    ack,
    output logic                    err,
    output logic                    rty,
    output logic [DATA_WIDTH-1:0]   dat_sm
);

    localparam int c_LANES = DATA_WIDTH / 8;
    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_BADR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dat;
    // Extra top bit flags a burst that has run past the last word.
    logic [DEPTH_LOG2:0]   r_badr;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_oor;
    logic                  w_burst_req;
    logic                  w_wr;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    assign w_idx       = adr[DEPTH_LOG2+1:2];
    assign w_oor       = |adr[ADDR_WIDTH-1:DEPTH_LOG2+2];
    assign w_burst_req = (cti == 3'b010) && (bte == 2'b00);
    assign w_rd_idx    = (r_state == S_BURST) ? r_badr[DEPTH_LOG2-1:0] : w_idx;
    assign w_rdata     = r_mem[w_rd_idx];
    assign w_wr        = r_ack & cyc & stb & we & ~w_oor;
    assign w_unused    = &{1'b0, adr[1:0]};

    assign ack    = r_ack;
    assign err    = r_err;
    assign rty    = 1'b0;
    assign dat_sm = r_dat;

    // Writes land at the edge closing the ack cycle, so a reset that clears
    // ack asynchronously also cancels the pending write.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (sel[i]) begin
                    r_mem[w_idx][8*i +: 8] <= dat_ms[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_badr  <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (!cyc) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (stb) begin
                            if (w_oor) begin
                                r_err   <= 1'b1;
                                r_state <= S_ACK;
                            end else begin
                                r_ack <= 1'b1;
                                r_dat <= w_rdata;
                                if (w_burst_req) begin
                                    r_badr  <= {1'b0, w_idx} + c_BADR_ONE;
                                    r_state <= S_BURST;
                                end else begin
                                    r_state <= S_ACK;
                                end
                            end
                        end
                    end
                    S_ACK: begin
                        r_state <= S_IDLE;
                    end
                    S_BURST: begin
                        if (stb && cti == 3'b010) begin
                            if (r_badr[DEPTH_LOG2]) begin
                                r_err   <= 1'b1;
                                r_state <= S_ACK;
                            end else begin
                                r_ack  <= 1'b1;
                                r_dat  <= w_rdata;
                                r_badr <= r_badr + c_BADR_ONE;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/wshb_ram_slave.md
Name: wshb_ram_slave

Overview:
- Wishbone B4 slave (responder) backed by on-chip single-port RAM; it is the target end of the master bus driven by the mire/VGA interconnect.
- Serves classic single cycles and linear incrementing bursts so the VGA reader can stream at one word per clock.
- Also used as a frame-buffer stand-in for simulation and for small on-chip buffers.

Parameters:
DATA_WIDTH, 32, data bus width (multiple of 8)
ADDR_WIDTH, 32, byte address width of adr
DEPTH_LOG2, 10, log2 of RAM depth in words (default 1024 words)

Ports:
clk  in  1  bus clock
rst  in  1  asynchronous reset, active-low
cyc  in  1  Wishbone cycle
stb  in  1  Wishbone strobe
we  in  1  write enable
adr  in  ADDR_WIDTH  byte address
dat_ms  in  DATA_WIDTH  write data
sel  in  DATA_WIDTH/8  byte lanes
cti  in  3  cycle type (000 classic, 010 incrementing, 111 end-of-burst)
bte  in  2  burst type (only 00 linear is burst-accelerated)
ack  out  1  normal termination
err  out  1  error termination
rty  out  1  retry, tied 0
dat_sm  out  DATA_WIDTH  read data

Behaviour:
- Reset (rst=0, async): ack=0, err=0, dat_sm=0, FSM=IDLE, burst address=0. RAM contents are not reset.
- Word index = adr[DEPTH_LOG2+1:2]. Out of range when adr[ADDR_WIDTH-1:DEPTH_LOG2+2] != 0. adr[1:0] ignored.
- Request = cyc & stb.
- All terminations are registered. Exactly one of ack/err is high per terminated beat, never both.
- Writes are committed at the clock edge ending a cycle with ack=1 & we=1, using the current adr/dat_ms/sel. Only lanes with sel[i]=1 are updated. sel=0 means ack with no change.
- Reads: RAM is read at the edge where the request is accepted (classic: adr; burst continuation: burst address). dat_sm is valid only in ack cycles. Outside ack it holds its last value.
- FSM:
  - IDLE: on request with ack=0:
    - out-of-range → err=1 next cycle, go to ACK; no write, dat_sm unchanged.
    - cti=010 & bte=00 → ack=1 next cycle, load burst address = word index + 1, go to BURST.
    - else → ack=1 next cycle, go to ACK.
  - ACK: ack/err=0 next cycle, back to IDLE. A classic request held high is therefore acked every other cycle (1 wait state).
  - BURST (ack high this cycle):
    - request & cti=010 → ack stays 1; next beat's read uses burst address; burst address increments.
    - cti=111 → this beat completes; ack=0 next cycle; go to IDLE.
    - stb=0 → ack=0 next cycle; go to IDLE (a resumed burst restarts with 1 wait state).
    - A continuation beat whose burst address leaves the range → err=1 for that beat, go to ACK.
- Burst address wraps modulo 2^DEPTH_LOG2 only for range checking of the high bits; a crossing past the top is an error, not a wrap.
- cyc=0 in any state: ack/err=0 next cycle, FSM=IDLE, no write in that cycle.
- Latency: first beat 1 cycle after request; burst continuation 0 wait states.
- Reset mid-burst: outputs zero immediately; a write in progress at that edge is not committed.

Test Plan:
- Classic write adr=0x10, dat_ms=0xDEADBEEF, sel=1111, then classic read adr=0x10 → ack one cycle after each request; read dat_sm=0xDEADBEEF.
- Byte-lane write sel=0010, dat_ms=0x0000AA00 to a word holding 0x11223344 → read returns 0x1122AA44.
- Read burst of 4 from adr=0x100 (cti 010,010,010,111), words preloaded 0..3 → ack high for 4 consecutive cycles; dat_sm=0,1,2,3; ack low next.
- Classic read adr=0x00001000 (DEPTH_LOG2=10, out of range) → err=1 for one cycle, ack=0; a write there leaves RAM unchanged.
- stb dropped after 2nd burst beat, then resumed → ack low 1 cycle after drop; resumed beat acked after 1 wait state with correct data.
- rst asserted mid-burst → ack/err/dat_sm =0 asynchronously; after release, a classic read returns previously written data.
